// File: rtl/cdpga_h_pkg.sv
// Shared types and constants for the CDPGA-H output test-pattern generator.
// Phase enum, phase lengths, pattern constants and the (phase, idx) -> pattern mapping.
package cdpga_h_pkg;

   localparam int OUT_W = 20;

   typedef enum logic [1:0] {
      WALK,
      FILL,
      ALT,
      COUNT
   } phase_t;

   localparam logic [6:0] WALK_LEN  = 7'd20;
   localparam logic [6:0] FILL_LEN  = 7'd20;
   localparam logic [6:0] ALT_LEN   = 7'd4;
   localparam logic [6:0] COUNT_LEN = 7'd64;

   localparam logic [OUT_W-1:0] ALT_A = 20'h55555;
   localparam logic [OUT_W-1:0] ALT_B = 20'hAAAAA;

   function automatic logic [6:0] phase_last(input phase_t ph);
      logic [6:0] len;
      len = WALK_LEN;
      case (ph)
         WALK:    len = WALK_LEN;
         FILL:    len = FILL_LEN;
         ALT:     len = ALT_LEN;
         COUNT:   len = COUNT_LEN;
         default: len = WALK_LEN;
      endcase
      return len - 7'd1;
   endfunction

   function automatic phase_t next_phase(input phase_t ph);
      phase_t nxt;
      nxt = WALK;
      case (ph)
         WALK:    nxt = FILL;
         FILL:    nxt = ALT;
         ALT:     nxt = COUNT;
         COUNT:   nxt = WALK;
         default: nxt = WALK;
      endcase
      return nxt;
   endfunction

   function automatic logic [OUT_W-1:0] pattern(input phase_t ph, input logic [6:0] idx);
      logic [OUT_W-1:0] val;
      logic [OUT_W:0]   therm;
      val   = '0;
      therm = ((OUT_W+1)'(2) << idx) - (OUT_W+1)'(1);
      case (ph)
         WALK:    val = OUT_W'(1) << idx;
         FILL:    val = therm[OUT_W-1:0];
         ALT:     val = idx[0] ? ALT_B : ALT_A;
         COUNT:   val = {{(OUT_W-6){1'b0}}, idx[5:0]};
         default: val = '0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cdpga_h_tick_div.sv
// Prescaler for the pattern sequencer: one-cycle tick every TICK_DIV clk cycles.
module cdpga_h_tick_div #(
   parameter int TICK_DIV = 250
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // A single-state counter still needs one bit; with TICK_DIV = 1 it stays at 0 and tick is constant.
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div;

   always_ff @(posedge clk) begin
      if (rst) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign tick = (div == DIV_LAST);

endmodule

// File: rtl/cdpga_h_io_test.sv
// CDPGA-H board output test image: walks, fills, alternates and counts on all 20 pins.
// Define CDPGA_H_HEARTBEAT_EN to replace out[19] with a 50-tick heartbeat square wave.
module cdpga_h_io_test
   import cdpga_h_pkg::*;
#(
   parameter int TICK_DIV = 250
) (
   input  logic             clk,
   input  logic             rst,
   output logic [OUT_W-1:0] out
);

   phase_t           phase;
   phase_t           phase_nxt;
   logic [6:0]       idx;
   logic [6:0]       idx_nxt;
   logic [OUT_W-1:0] out_nxt;
   logic             tick;

   cdpga_h_tick_div #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_div (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

`ifdef CDPGA_H_HEARTBEAT_EN
   logic       hb;
   logic [5:0] hb_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         hb     <= 1'b0;
         hb_cnt <= '0;
      end else if (tick) begin
         if (hb_cnt == 6'd49) begin
            hb_cnt <= '0;
            hb     <= ~hb;
         end else begin
            hb_cnt <= hb_cnt + 6'd1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= WALK;
         idx   <= '0;
         out   <= '0;
      end else begin
         phase <= phase_nxt;
         idx   <= idx_nxt;
         out   <= out_nxt;
      end
   end

   // The output reflects the current (phase, idx), so each step appears one cycle after it is entered.
   always_comb begin
      phase_nxt = phase;
      idx_nxt   = idx;
      out_nxt   = pattern(phase, idx);
      if (tick) begin
         if (idx == phase_last(phase)) begin
            idx_nxt   = '0;
            phase_nxt = next_phase(phase);
         end else begin
            idx_nxt = idx + 7'd1;
         end
      end
`ifdef CDPGA_H_HEARTBEAT_EN
      out_nxt[OUT_W-1] = hb;
`endif
   end

endmodule

// File: tb/tb_cdpga_h_io_test.sv
// Self-checking bench for cdpga_h_io_test with TICK_DIV = 4.
// Honours CDPGA_H_HEARTBEAT_EN: the reference model then drives bit 19 from the tick count.
module tb_cdpga_h_io_test;

   localparam int TICK_DIV = 4;
   localparam int SEQ_LEN  = 108;

`ifdef CDPGA_H_HEARTBEAT_EN
   localparam logic [19:0] TABLE_MASK = 20'h7FFFF;
`else
   localparam logic [19:0] TABLE_MASK = 20'hFFFFF;
`endif

   typedef struct {
      int          edge_n;
      logic [19:0] expected;
      string       name;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [19:0] out;

   int   checks;
   int   errors;
   int   k;
   vec_t vecs[$];

   cdpga_h_io_test #(
      .TICK_DIV(TICK_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .out(out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output on the k-th rising edge after reset release, from the step number alone.
   function automatic logic [19:0] refOut(input int edge_n);
      int          step;
      logic [19:0] v;
      step = ((edge_n - 1) / TICK_DIV) % SEQ_LEN;
      if (step < 20)
         v = 20'(1 << step);
      else if (step < 40)
         v = 20'((1 << (step - 20 + 1)) - 1);
      else if (step < 44)
         v = ((step - 40) % 2 == 1) ? 20'hAAAAA : 20'h55555;
      else
         v = 20'(step - 44);
`ifdef CDPGA_H_HEARTBEAT_EN
      v[19] = (((edge_n - 1) / (50 * TICK_DIV)) % 2) == 1;
`endif
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [19:0] expected, input logic [19:0] mask);
      checks++;
      if ((out & mask) !== (expected & mask)) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %05h want %05h", name, k, out & mask, expected & mask);
      end
   endtask

   // One clock with rst driven to r; then compare against the model and any table entry for this edge.
   task automatic applyStimulus(input logic r);
      rst = r;
      @(posedge clk);
      #1;
      if (r) begin
         k = 0;
         checkOutput("reset", 20'h00000, 20'hFFFFF);
      end else begin
         k++;
         checkOutput("model", refOut(k), 20'hFFFFF);
         foreach (vecs[i]) begin
            if (vecs[i].edge_n == k)
               checkOutput(vecs[i].name, vecs[i].expected, TABLE_MASK);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      k      = 0;
      rst    = 1'b1;

      vecs.push_back('{1,   20'h00001, "walk0_first"});
      vecs.push_back('{4,   20'h00001, "walk0_last"});
      vecs.push_back('{5,   20'h00002, "walk1_first"});
      vecs.push_back('{80,  20'h80000, "walk19"});
      vecs.push_back('{81,  20'h00001, "fill0"});
      vecs.push_back('{85,  20'h00003, "fill1"});
      vecs.push_back('{160, 20'hFFFFF, "fill19"});
      vecs.push_back('{161, 20'h55555, "alt0"});
      vecs.push_back('{165, 20'hAAAAA, "alt1"});
      vecs.push_back('{169, 20'h55555, "alt2"});
      vecs.push_back('{173, 20'hAAAAA, "alt3"});
      vecs.push_back('{177, 20'h00000, "count0"});
      vecs.push_back('{432, 20'h0003F, "count63"});
      vecs.push_back('{433, 20'h00001, "wrap_walk0"});
      vecs.push_back('{437, 20'h00002, "wrap_walk1"});

      $display("[TB] reset held for 3 cycles");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1);

      $display("[TB] one full sequence plus wrap");
      for (int i = 0; i < 440; i++) applyStimulus(1'b0);

      $display("[TB] reset in the middle of COUNT step 10");
      applyStimulus(1'b1);
      while (k < 218) applyStimulus(1'b0);
      checkOutput("count_step10", 20'h0000A, TABLE_MASK);
      applyStimulus(1'b1);
      checkOutput("mid_count_reset", 20'h00000, 20'hFFFFF);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0);
         checkOutput("restart", (i < 5) ? 20'h00001 : 20'h00002, TABLE_MASK);
      end

      $display("[TB] randomized reset pulses");
      for (int r = 0; r < 8; r++) begin
         int run_len;
         int rst_len;
         run_len = int'($urandom_range(1, 500));
         rst_len = int'($urandom_range(1, 3));
         for (int i = 0; i < rst_len; i++) applyStimulus(1'b1);
         for (int i = 0; i < run_len; i++) applyStimulus(1'b0);
      end

      $display("[TB] long run for heartbeat period");
      applyStimulus(1'b1);
      for (int i = 0; i < 900; i++) applyStimulus(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
